// File: rtl/aoc_pkg.sv
// Shared types and constants for the AoC run controller and its helpers.
package aoc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    STREAM   = 3'd2,
    FLUSH_NL = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } run_state_t;

  localparam logic [DATA_W-1:0] CHAR_NL = 8'h0A;
  localparam logic [DATA_W-1:0] CHAR_0  = 8'h30;
  localparam logic [DATA_W-1:0] CHAR_9  = 8'h39;

  function automatic logic is_nl(input logic [DATA_W-1:0] b);
    return b == CHAR_NL;
  endfunction

endpackage

// File: rtl/aoc_run_ctrl_if.sv
// Byte-stream handshake: valid/ready with a last-byte qualifier.
interface aoc_run_ctrl_if;
  import aoc_pkg::*;

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/aoc_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module aoc_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/aoc_run_ctrl.sv
// Run controller: soft-resets the solver, streams one file into it, closes the
// file with a newline if needed, then waits a drain period and captures the result.
module aoc_run_ctrl
  import aoc_pkg::*;
#(
  parameter int unsigned RESULT_W     = 64,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  aoc_run_ctrl_if.slave       src,
  aoc_run_ctrl_if.master      sol,
  output logic                sol_rst_n,
  input  logic [RESULT_W-1:0] sol_result,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result,
  output logic [CNT_W-1:0]    byte_count,
  output logic [CNT_W-1:0]    line_count
);

  localparam int unsigned TMR_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  run_state_t       state;
  logic [TMR_W-1:0] timer;

  logic in_stream;
  logic in_flush;
  logic start_ok;
  logic xfer;

  assign in_stream = (state == STREAM);
  assign in_flush  = (state == FLUSH_NL);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  // Solver sees the host directly while streaming, the injected newline while flushing.
  assign src.ready = in_stream && sol.ready;
  assign sol.valid = in_stream ? src.valid : in_flush;
  assign sol.data  = in_stream ? src.data : (in_flush ? CHAR_NL : '0);
  assign sol.last  = (in_stream && src.last) || in_flush;
  assign xfer      = sol.valid && sol.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      sol_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          sol_rst_n <= 1'b1;
          if (start_ok) begin
            state     <= CLEAR;
            timer     <= TMR_W'(CLEAR_CYCLES - 1);
            sol_rst_n <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
          end
        end
        CLEAR: begin
          if (timer == '0) begin
            state     <= STREAM;
            sol_rst_n <= 1'b1;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        STREAM: begin
          if (xfer && src.last) begin
            state <= is_nl(src.data) ? DRAIN : FLUSH_NL;
            timer <= TMR_W'(DRAIN_CYCLES - 1);
          end
        end
        FLUSH_NL: begin
          if (xfer) begin
            state <= DRAIN;
            timer <= TMR_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (timer == '0) begin
            state  <= DONE;
            result <= sol_result;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          sol_rst_n <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  aoc_sat_counter #(.W(CNT_W)) u_byte_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .inc   (xfer),
    .q     (byte_count)
  );

  aoc_sat_counter #(.W(CNT_W)) u_line_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .inc   (xfer && is_nl(sol.data)),
    .q     (line_count)
  );

endmodule

// File: tb/tb_aoc_run_ctrl.sv
// Bench for aoc_run_ctrl: directed and random files against an adding solver stub
// and a reference model computed from the file contents.
module tb_aoc_run_ctrl;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sol_rst_n;
  logic [63:0] sol_acc;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [31:0] byte_count;
  logic [31:0] line_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  aoc_run_ctrl_if src_if ();
  aoc_run_ctrl_if sol_if ();

  aoc_run_ctrl #(
    .RESULT_W     (64),
    .CLEAR_CYCLES (2),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src        (src_if),
    .sol        (sol_if),
    .sol_rst_n  (sol_rst_n),
    .sol_result (sol_acc),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .byte_count (byte_count),
    .line_count (line_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Solver stub: running sum of every accepted byte, cleared by its soft reset.
  always_ff @(posedge clk) begin
    if (!sol_rst_n) sol_acc <= '0;
    else if (sol_if.valid && sol_if.ready) sol_acc <= sol_acc + 64'(sol_if.data);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: toggling every cycle, 2: random
  task automatic drive_ready(input int mode);
    case (mode)
      0:       sol_if.ready = 1'b1;
      1:       sol_if.ready = (cyc % 2) == 0;
      default: sol_if.ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_file(input bq_t f, input int mode, input bit gaps,
                          input bit start_mid, input int abort_at);
    bq_t         got;
    bq_t         exp_q;
    logic [63:0] exp_sum;
    int          exp_lines;
    int          idx, lowc, n, guard, bad;
    bit          flush;

    exp_q = f;
    flush = (f[f.size()-1] != 8'h0A);
    if (flush) exp_q.push_back(8'h0A);
    exp_sum   = '0;
    exp_lines = 0;
    foreach (exp_q[i]) begin
      exp_sum = exp_sum + 64'(exp_q[i]);
      if (exp_q[i] == 8'h0A) exp_lines++;
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_busy", 64'(busy), 64'd1);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_bytes", 64'(byte_count), 64'd0);
    chk("clr_lines", 64'(line_count), 64'd0);
    chk("clr_result", result, 64'd0);
    lowc = 0;
    while (sol_rst_n === 1'b0 && lowc < 10) begin
      lowc++;
      @(negedge clk);
    end
    chk("clr_len", 64'(lowc), 64'd2);

    idx   = 0;
    guard = 0;
    while (idx < f.size() && (abort_at < 0 || idx < abort_at) && guard < 2000) begin
      guard++;
      cyc++;
      src_if.valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_if.data  = f[idx];
      src_if.last  = (idx == f.size() - 1);
      start        = start_mid && (idx == 1);
      drive_ready(mode);
      #1;
      if (src_if.valid && src_if.ready) idx++;
      if (sol_if.valid && sol_if.ready) got.push_back(sol_if.data);
      @(negedge clk);
    end
    src_if.valid = 1'b0;
    src_if.last  = 1'b0;
    start        = 1'b0;

    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      chk("abort_sol_rst_n", 64'(sol_rst_n), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_bytes", 64'(byte_count), 64'd0);
      chk("abort_lines", 64'(line_count), 64'd0);
      chk("abort_src_ready", 64'(src_if.ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end
    chk("stream_timeout", 64'(idx), 64'(f.size()));

    n = 0;
    while (done !== 1'b1 && n < 200) begin
      cyc++;
      drive_ready(mode);
      #1;
      if (sol_if.valid && sol_if.ready) got.push_back(sol_if.data);
      n++;
      @(negedge clk);
    end
    if (mode == 0) chk("done_latency", 64'(n), 64'(2 + (flush ? 1 : 0)));
    chk("done", 64'(done), 64'd1);
    chk("busy_off", 64'(busy), 64'd0);
    chk("result", result, exp_sum);
    chk("byte_count", 64'(byte_count), 64'(exp_q.size()));
    chk("line_count", 64'(line_count), 64'(exp_lines));
    chk("stream_len", 64'(got.size()), 64'(exp_q.size()));
    bad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    chk("stream_bytes", 64'(bad), 64'd0);

    src_if.valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("done_src_ready", 64'(src_if.ready), 64'd0);
    chk("done_hold", result, exp_sum);
    src_if.valid = 1'b0;
  endtask

  bq_t f_abn;
  bq_t f_ab;
  bq_t f_lines;
  bq_t f_rnd;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    src_if.valid = 1'b0;
    src_if.data  = 8'h00;
    src_if.last  = 1'b0;
    sol_if.ready = 1'b1;
    f_abn   = '{8'h61, 8'h62, 8'h0A};
    f_ab    = '{8'h61, 8'h62};
    f_lines = '{8'h31, 8'h32, 8'h0A, 8'h33, 8'h34, 8'h0A};

    repeat (3) @(negedge clk);
    chk("rst_sol_rst_n", 64'(sol_rst_n), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_src_ready", 64'(src_if.ready), 64'd0);
    chk("rst_sol_data", 64'(sol_if.data), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_bytes", 64'(byte_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    src_if.valid = 1'b1;
    #1;
    chk("idle_sol_rst_n", 64'(sol_rst_n), 64'd1);
    chk("idle_src_ready", 64'(src_if.ready), 64'd0);
    chk("idle_sol_valid", 64'(sol_if.valid), 64'd0);
    src_if.valid = 1'b0;

    run_file(f_abn, 0, 1'b0, 1'b0, -1);
    run_file(f_ab, 0, 1'b0, 1'b0, -1);
    run_file(f_lines, 1, 1'b0, 1'b0, -1);
    run_file(f_lines, 0, 1'b1, 1'b1, -1);
    run_file(f_abn, 0, 1'b0, 1'b0, -1);
    run_file(f_lines, 0, 1'b0, 1'b0, 3);
    run_file(f_lines, 0, 1'b0, 1'b0, -1);
    run_file(f_ab, 2, 1'b1, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      int len;
      len = int'($urandom_range(1, 12));
      f_rnd.delete();
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 3))
          0:       f_rnd.push_back(8'h0A);
          1:       f_rnd.push_back(8'h61);
          default: f_rnd.push_back(8'(8'h30 + $urandom_range(0, 9)));
        endcase
      end
      run_file(f_rnd, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
